// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data memory between the
// CPU load/store path and the FFT memory engine. One access per cycle,
// round-robin between CPU beats and locked FFT bursts, 1-cycle read return
// routed to the owning requester, and a saturating CPU stall counter.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              fft_req,
  input  logic              fft_we,
  input  logic [ADDR_W-1:0] fft_addr,
  input  logic [DATA_W-1:0] fft_wdata,
  input  logic              fft_last,
  output logic              fft_ready,
  output logic              fft_rvalid,
  output logic [DATA_W-1:0] fft_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       cpu_stall_cnt
);

  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BURST);
  localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic              last_r;        // 0 = CPU won last, 1 = FFT won last
  logic              last_next_s;
  logic [BEAT_W-1:0] beat_r;
  logic [BEAT_W-1:0] beat_next_s;
  logic [BEAT_W-1:0] beat_inc_s;
  logic              burst_end_s;
  logic              cpu_grant_s;
  logic              fft_grant_s;
  logic              rtag_valid_r;
  logic              rtag_owner_r;  // 0 = CPU, 1 = FFT

  assign beat_inc_s  = beat_r + BEAT_ONE;
  assign burst_end_s = fft_last | (beat_inc_s == BEAT_MAX);

  // State register plus lock bookkeeping (winner history and beat count)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      last_r  <= 1'b1;
      beat_r  <= {BEAT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      last_r  <= last_next_s;
      beat_r  <= beat_next_s;
    end
  end

  // Next-state logic: enter lock on a multi-beat FFT grant, leave on last beat or MAX_BURST
  always_comb begin
    state_next_s = state_r;
    last_next_s  = last_r;
    beat_next_s  = beat_r;
    case (state_r)
      ST_IDLE: begin
        if (cpu_req && fft_req) begin
          last_next_s = fft_grant_s;
        end else begin
          last_next_s = last_r;
        end
        if (fft_grant_s && !fft_last) begin
          state_next_s = ST_LOCK;
          beat_next_s  = BEAT_ONE;
        end else begin
          state_next_s = ST_IDLE;
          beat_next_s  = {BEAT_W{1'b0}};
        end
      end
      ST_LOCK: begin
        if (fft_grant_s) begin
          if (burst_end_s) begin
            // Hand the next conflict to the CPU after every burst
            state_next_s = ST_IDLE;
            last_next_s  = 1'b1;
            beat_next_s  = {BEAT_W{1'b0}};
          end else begin
            beat_next_s  = beat_inc_s;
          end
        end else begin
          beat_next_s = beat_r;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        last_next_s  = 1'b1;
        beat_next_s  = {BEAT_W{1'b0}};
      end
    endcase
  end

  // Output logic: grant decision from state, requests and last winner
  always_comb begin
    cpu_grant_s = 1'b0;
    fft_grant_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cpu_req && fft_req) begin
          cpu_grant_s = last_r;
          fft_grant_s = ~last_r;
        end else begin
          cpu_grant_s = cpu_req;
          fft_grant_s = fft_req;
        end
      end
      ST_LOCK: begin
        cpu_grant_s = 1'b0;
        fft_grant_s = fft_req;
      end
      default: begin
        cpu_grant_s = 1'b0;
        fft_grant_s = 1'b0;
      end
    endcase
  end

  assign cpu_ready = cpu_grant_s & ~reset;
  assign fft_ready = fft_grant_s & ~reset;

  // Memory port mux: granted requester drives the memory, all zero otherwise
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if (cpu_ready) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (fft_ready) begin
      mem_en    = 1'b1;
      mem_we    = fft_we;
      mem_addr  = fft_addr;
      mem_wdata = fft_wdata;
    end else begin
      mem_en    = 1'b0;
    end
  end

  // Read tag: remembers whether this cycle's access was a read and who owns it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rtag_valid_r <= 1'b0;
      rtag_owner_r <= 1'b0;
    end else begin
      rtag_valid_r <= (cpu_ready & ~cpu_we) | (fft_ready & ~fft_we);
      rtag_owner_r <= fft_ready;
    end
  end

  // Read return routing: only the owner of the pending read sees data
  always_comb begin
    cpu_rvalid = rtag_valid_r & ~rtag_owner_r;
    fft_rvalid = rtag_valid_r & rtag_owner_r;
    if (cpu_rvalid) begin
      cpu_rdata = mem_rdata;
    end else begin
      cpu_rdata = {DATA_W{1'b0}};
    end
    if (fft_rvalid) begin
      fft_rdata = mem_rdata;
    end else begin
      fft_rdata = {DATA_W{1'b0}};
    end
  end

  // Saturating count of cycles where the CPU waits for the memory
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_stall_cnt <= 16'd0;
    end else if (cpu_req && !cpu_ready && (cpu_stall_cnt != 16'hFFFF)) begin
      cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
    end else begin
      cpu_stall_cnt <= cpu_stall_cnt;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed table, multi-cycle corner sequences
// and randomized traffic checked against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int MAXB = 16;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_ready, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        fft_req, fft_we, fft_last;
  logic [31:0] fft_addr, fft_wdata;
  logic        fft_ready, fft_rvalid;
  logic [31:0] fft_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] cpu_stall_cnt;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .fft_req(fft_req), .fft_we(fft_we), .fft_addr(fft_addr), .fft_wdata(fft_wdata),
    .fft_last(fft_last), .fft_ready(fft_ready), .fft_rvalid(fft_rvalid), .fft_rdata(fft_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_stall_cnt(cpu_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory environment: single-port synchronous RAM, 1-cycle read latency
  logic [31:0] env_mem [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) env_mem[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= env_mem[mem_addr[9:2]];
    end
  end

  typedef struct packed {
    logic        rst;
    logic        creq;
    logic        cwe;
    logic [31:0] caddr;
    logic [31:0] cwd;
    logic        freq;
    logic        fwe;
    logic [31:0] faddr;
    logic [31:0] fwd;
    logic        flast;
  } in_t;

  typedef struct packed {
    in_t         i;
    logic        crdy;
    logic        frdy;
    logic        crv;
    logic [31:0] crd;
    logic        frv;
    logic [31:0] frd;
    logic [15:0] stall;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: transaction-level view of ownership and pending reads
  bit          m_locked;
  bit          m_last_fft;
  int          m_beats;
  bit          m_pend;
  bit          m_pend_fft;
  logic [31:0] m_pend_data;
  int          m_stall;
  logic [31:0] ref_mem [0:255];

  // Observed DUT outputs of the most recent cycle
  logic        o_crdy, o_frdy, o_crv, o_frv;
  logic [31:0] o_crd, o_frd;
  logic [15:0] o_stall;

  function automatic in_t mk(input logic rst, input logic creq, input logic cwe,
                             input logic [31:0] caddr, input logic [31:0] cwd,
                             input logic freq, input logic fwe, input logic [31:0] faddr,
                             input logic [31:0] fwd, input logic flast);
    in_t r;
    r.rst = rst; r.creq = creq; r.cwe = cwe; r.caddr = caddr; r.cwd = cwd;
    r.freq = freq; r.fwe = fwe; r.faddr = faddr; r.fwd = fwd; r.flast = flast;
    return r;
  endfunction

  function automatic vec_t mkv(input in_t i, input logic crdy, input logic frdy,
                               input logic crv, input logic [31:0] crd,
                               input logic frv, input logic [31:0] frd,
                               input logic [15:0] stall);
    vec_t v;
    v.i = i; v.crdy = crdy; v.frdy = frdy; v.crv = crv; v.crd = crd;
    v.frv = frv; v.frd = frd; v.stall = stall;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked   = 1'b0;
    m_last_fft = 1'b1;
    m_beats    = 0;
    m_pend     = 1'b0;
    m_pend_fft = 1'b0;
    m_stall    = 0;
  endtask

  // One clock cycle: drive inputs, check every output against the model, advance model
  task automatic cycle(input in_t x);
    bit e_c, e_f, e_en, e_we;
    logic [31:0] e_addr, e_wd;
    @(negedge clk);
    reset = x.rst; cpu_req = x.creq; cpu_we = x.cwe; cpu_addr = x.caddr; cpu_wdata = x.cwd;
    fft_req = x.freq; fft_we = x.fwe; fft_addr = x.faddr; fft_wdata = x.fwd; fft_last = x.flast;
    #1;
    if (x.rst) model_reset();
    if (x.rst) begin
      e_c = 1'b0; e_f = 1'b0;
    end else if (m_locked) begin
      e_c = 1'b0; e_f = x.freq;
    end else if (x.creq && x.freq) begin
      e_c = m_last_fft; e_f = !m_last_fft;
    end else begin
      e_c = x.creq; e_f = x.freq;
    end
    e_en = e_c || e_f;
    e_we = e_c ? x.cwe : (e_f ? x.fwe : 1'b0);
    e_addr = e_c ? x.caddr : (e_f ? x.faddr : 32'h0);
    e_wd = e_c ? x.cwd : (e_f ? x.fwd : 32'h0);
    chk("cpu_ready", {31'd0, cpu_ready}, {31'd0, e_c});
    chk("fft_ready", {31'd0, fft_ready}, {31'd0, e_f});
    chk("mem_en", {31'd0, mem_en}, {31'd0, e_en});
    chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, m_pend && !m_pend_fft});
    chk("cpu_rdata", cpu_rdata, (m_pend && !m_pend_fft) ? m_pend_data : 32'h0);
    chk("fft_rvalid", {31'd0, fft_rvalid}, {31'd0, m_pend && m_pend_fft});
    chk("fft_rdata", fft_rdata, (m_pend && m_pend_fft) ? m_pend_data : 32'h0);
    chk("stall_cnt", {16'd0, cpu_stall_cnt}, m_stall);
    o_crdy = cpu_ready; o_frdy = fft_ready; o_crv = cpu_rvalid; o_frv = fft_rvalid;
    o_crd = cpu_rdata; o_frd = fft_rdata; o_stall = cpu_stall_cnt;
    if (!x.rst) begin
      if (x.creq && !e_c) m_stall = (m_stall >= 65535) ? 65535 : m_stall + 1;
      m_pend = 1'b0;
      if (e_c) begin
        if (x.cwe) ref_mem[x.caddr[9:2]] = x.cwd;
        else begin m_pend = 1'b1; m_pend_fft = 1'b0; m_pend_data = ref_mem[x.caddr[9:2]]; end
      end
      if (e_f) begin
        if (x.fwe) ref_mem[x.faddr[9:2]] = x.fwd;
        else begin m_pend = 1'b1; m_pend_fft = 1'b1; m_pend_data = ref_mem[x.faddr[9:2]]; end
      end
      if (!m_locked && x.creq && x.freq) m_last_fft = e_f;
      if (e_f) begin
        if (m_locked) begin
          m_beats++;
          if (x.flast || m_beats == MAXB) begin
            m_locked = 1'b0; m_last_fft = 1'b1; m_beats = 0;
          end
        end else if (!x.flast) begin
          m_locked = 1'b1; m_beats = 1;
        end
      end
    end
  endtask

  in_t  idle_in;
  in_t  rst_in;
  vec_t tbl [0:15];

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    fft_req = 1'b0; fft_we = 1'b0; fft_addr = 32'h0; fft_wdata = 32'h0; fft_last = 1'b0;
    model_reset();
    idle_in = mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    rst_in  = mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // ---------------- directed table ----------------
    tbl[0]  = mkv(rst_in, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 16'd0);
    tbl[1]  = mkv(mk(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0),
                  1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 16'd0);
    tbl[2]  = mkv(mk(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0),
                  1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 16'd0);
    tbl[3]  = mkv(idle_in, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 16'd0);
    tbl[4]  = mkv(rst_in, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 16'd0);
    tbl[5]  = mkv(mk(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1),
                  1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 16'd0);
    tbl[6]  = mkv(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1),
                  1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 16'd0);
    tbl[7]  = mkv(idle_in, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 16'd0);
    tbl[8]  = mkv(mk(1'b0, 1'b1, 1'b1, 32'h20, 32'h11, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0),
                  1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 16'd0);
    tbl[9]  = mkv(mk(1'b0, 1'b1, 1'b1, 32'h24, 32'h22, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0),
                  1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 16'd0);
    tbl[10] = mkv(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1),
                  1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 16'd0);
    tbl[11] = mkv(mk(1'b0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0),
                  1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h11, 16'd0);
    tbl[12] = mkv(idle_in, 1'b0, 1'b0, 1'b1, 32'h22, 1'b0, 32'h0, 16'd0);
    tbl[13] = mkv(mk(1'b0, 1'b1, 1'b1, 32'h30, 32'h1, 1'b1, 1'b1, 32'h34, 32'h2, 1'b1),
                  1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 16'd0);
    tbl[14] = mkv(mk(1'b0, 1'b1, 1'b1, 32'h30, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0),
                  1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 16'd1);
    tbl[15] = mkv(idle_in, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 16'd1);

    for (int r = 0; r < 16; r++) begin
      cycle(tbl[r].i);
      chk($sformatf("row%0d_cpu_ready", r), {31'd0, o_crdy}, {31'd0, tbl[r].crdy});
      chk($sformatf("row%0d_fft_ready", r), {31'd0, o_frdy}, {31'd0, tbl[r].frdy});
      chk($sformatf("row%0d_cpu_rvalid", r), {31'd0, o_crv}, {31'd0, tbl[r].crv});
      chk($sformatf("row%0d_cpu_rdata", r), o_crd, tbl[r].crd);
      chk($sformatf("row%0d_fft_rvalid", r), {31'd0, o_frv}, {31'd0, tbl[r].frv});
      chk($sformatf("row%0d_fft_rdata", r), o_frd, tbl[r].frd);
      chk($sformatf("row%0d_stall", r), {16'd0, o_stall}, {16'd0, tbl[r].stall});
    end

    // ---------------- 4-beat FFT write burst against a busy CPU ----------------
    begin
      logic [5:0] ec;
      logic [5:0] ef;
      int cidx;
      int fidx;
      ec = 6'b100001; ef = 6'b011110; cidx = 0; fidx = 0;
      cycle(rst_in);
      for (int k = 0; k < 6; k++) begin
        cycle(mk(1'b0, 1'b1, 1'b1, 32'h100 + 32'(4 * cidx), 32'hC000 + 32'(cidx),
                 fidx < 4, 1'b1, 32'h200 + 32'(4 * fidx), 32'hF000 + 32'(fidx), fidx == 3));
        chk($sformatf("burst%0d_cpu_ready", k), {31'd0, o_crdy}, {31'd0, ec[k]});
        chk($sformatf("burst%0d_fft_ready", k), {31'd0, o_frdy}, {31'd0, ef[k]});
        if (k == 5) chk("burst_stall_total", {16'd0, o_stall}, 32'd4);
        if (o_crdy) cidx++;
        if (o_frdy) fidx++;
      end
    end

    // ---------------- forced release at MAX_BURST ----------------
    begin
      logic [20:0] ec;
      logic [20:0] ef;
      int fidx;
      ec = 21'h010000; ef = 21'h1EFFFF; fidx = 0;
      cycle(rst_in);
      for (int k = 0; k < 21; k++) begin
        cycle(mk(1'b0, k > 0, 1'b1, 32'h300, 32'hAAAA,
                 fidx < 20, 1'b1, 32'h000 + 32'(4 * fidx), 32'hB000 + 32'(fidx), 1'b0));
        chk($sformatf("force%0d_cpu_ready", k), {31'd0, o_crdy}, {31'd0, ec[k]});
        chk($sformatf("force%0d_fft_ready", k), {31'd0, o_frdy}, {31'd0, ef[k]});
        if (k == 20) chk("force_stall_total", {16'd0, o_stall}, 32'd18);
        if (o_frdy) fidx++;
      end
    end

    // ---------------- reset in beat 3 of an FFT read burst ----------------
    cycle(rst_in);
    cycle(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0));
    cycle(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0));
    chk("rstmid_beat1_rvalid", {31'd0, o_frv}, 32'd1);
    cycle(mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h28, 32'h0, 1'b0));
    chk("rstmid_fft_ready", {31'd0, o_frdy}, 32'd0);
    chk("rstmid_fft_rvalid", {31'd0, o_frv}, 32'd0);
    cycle(idle_in);
    chk("rstmid_after_fft_rvalid", {31'd0, o_frv}, 32'd0);
    chk("rstmid_after_cpu_rvalid", {31'd0, o_crv}, 32'd0);
    cycle(mk(1'b0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1));
    chk("rstmid_conflict_cpu", {31'd0, o_crdy}, 32'd1);
    chk("rstmid_conflict_fft", {31'd0, o_frdy}, 32'd0);

    // ---------------- preload memory, then randomized traffic ----------------
    cycle(rst_in);
    for (int a = 0; a < 256; a++)
      cycle(mk(1'b0, 1'b1, 1'b1, 32'(a * 4), $urandom, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
    begin
      bit cp, c_we, f_have, f_we, rst_now;
      logic [31:0] c_addr, c_wd, f_addr, f_wd;
      int f_rem;
      cp = 1'b0; f_have = 1'b0; f_rem = 0; c_we = 1'b0; f_we = 1'b0;
      c_addr = 32'h0; c_wd = 32'h0; f_addr = 32'h0; f_wd = 32'h0;
      for (int n = 0; n < 4000; n++) begin
        rst_now = ($urandom_range(0, 299) == 0);
        if (!cp && $urandom_range(0, 2) != 0) begin
          cp = 1'b1; c_we = 1'($urandom_range(0, 1));
          c_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00}; c_wd = $urandom;
        end
        if (!f_have) begin
          if (f_rem == 0 && $urandom_range(0, 3) == 0) begin
            f_rem = $urandom_range(1, 20); f_we = 1'($urandom_range(0, 1));
            f_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
          end
          if (f_rem > 0 && $urandom_range(0, 3) != 0) begin
            f_have = 1'b1; f_wd = $urandom;
          end
        end
        cycle(mk(rst_now, cp, c_we, c_addr, c_wd, f_have, f_we, f_addr, f_wd, f_rem == 1));
        if (rst_now) begin
          cp = 1'b0; f_have = 1'b0; f_rem = 0;
        end else begin
          if (o_crdy) cp = 1'b0;
          if (o_frdy) begin
            f_have = 1'b0; f_rem--;
            f_addr = {22'd0, f_addr[9:2] + 8'd1, 2'b00};
          end
        end
      end
    end

    // ---------------- stall counter saturation ----------------
    cycle(rst_in);
    cycle(mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h5, 1'b0));
    for (int j = 0; j < 65540; j++) begin
      cycle(mk(1'b0, 1'b1, 1'b1, 32'h44, 32'h6, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
      if (j == 65534) chk("stall_near_sat", {16'd0, o_stall}, 32'h0000FFFE);
      if (j == 65539) chk("stall_saturated", {16'd0, o_stall}, 32'h0000FFFF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
